// File: rtl/alu.sv
// 8-bit ALU with 16-bit pair extensions for the CPU datapath.
// Operands are sampled on every rising edge. Results and flags are registered,
// so they appear one cycle after the inputs.
// Flag layout: [0]=Z, [1]=C, [2]=V, [3]=N.
module alu #(
    parameter int INOUT_WIDTH = 8,
    parameter int FLAGS_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [4:0]             oper,
    input  logic [INOUT_WIDTH-1:0] a_in_lo,
    input  logic [INOUT_WIDTH-1:0] a_in_hi,
    input  logic [INOUT_WIDTH-1:0] b_in,
    input  logic [FLAGS_WIDTH-1:0] proc_flags_in,
    output logic [INOUT_WIDTH-1:0] out_lo,
    output logic [INOUT_WIDTH-1:0] out_hi,
    output logic [FLAGS_WIDTH-1:0] proc_flags_out
);

    localparam int W   = INOUT_WIDTH;
    localparam int W1  = W + 1;
    localparam int PW  = 2 * W;
    localparam int PW1 = PW + 1;

    localparam logic [W-1:0] ROT_W   = W'(W);
    localparam logic [W-1:0] ROT_PW  = W'(PW);
    localparam logic [W-1:0] ROT_W1  = W'(W1);
    localparam logic [W-1:0] ROT_PW1 = W'(PW1);

    localparam logic [4:0] OP_ADD   = 5'd0,  OP_ADC   = 5'd1,  OP_SUB   = 5'd2;
    localparam logic [4:0] OP_SBC   = 5'd3,  OP_CMP   = 5'd4,  OP_AND   = 5'd5;
    localparam logic [4:0] OP_ORR   = 5'd6,  OP_XOR   = 5'd7,  OP_INV   = 5'd8;
    localparam logic [4:0] OP_INVP  = 5'd9,  OP_NEG   = 5'd10, OP_NEGP  = 5'd11;
    localparam logic [4:0] OP_LSL   = 5'd12, OP_LSR   = 5'd13, OP_ASR   = 5'd14;
    localparam logic [4:0] OP_ROL   = 5'd15, OP_ROR   = 5'd16, OP_ROLC  = 5'd17;
    localparam logic [4:0] OP_RORC  = 5'd18, OP_LSLP  = 5'd19, OP_LSRP  = 5'd20;
    localparam logic [4:0] OP_ASRP  = 5'd21, OP_ROLP  = 5'd22, OP_RORP  = 5'd23;
    localparam logic [4:0] OP_ROLCP = 5'd24, OP_RORCP = 5'd25;

    logic          c_in, v_in;
    logic [PW-1:0] pair_in;

    assign c_in    = proc_flags_in[1];
    assign v_in    = proc_flags_in[2];
    assign pair_in = {a_in_hi, a_in_lo};

    // Adder and subtractor carry an extra top bit for carry/borrow out.
    // neg reuses the subtractor as 0 - a.
    logic [W:0]    add_full, sub_full;
    logic [W-1:0]  sub_x, sub_y;
    logic          add_v, sub_v, sub_c, borrow_in;
    logic [PW:0]   negp_full;

    assign add_full  = {1'b0, a_in_lo} + {1'b0, b_in} + {{W{1'b0}}, (oper == OP_ADC) & c_in};
    assign add_v     = (a_in_lo[W-1] ~^ b_in[W-1]) & (add_full[W-1] ^ a_in_lo[W-1]);
    assign sub_x     = (oper == OP_NEG) ? '0 : a_in_lo;
    assign sub_y     = (oper == OP_NEG) ? a_in_lo : b_in;
    assign borrow_in = (oper == OP_SBC) & ~c_in;
    assign sub_full  = {1'b0, sub_x} - {1'b0, sub_y} - {{W{1'b0}}, borrow_in};
    assign sub_c     = ~sub_full[W];
    assign sub_v     = (sub_x[W-1] ^ sub_y[W-1]) & (sub_full[W-1] ^ sub_x[W-1]);
    assign negp_full = {(PW+1){1'b0}} - {1'b0, pair_in};

    // Shifts carry one guard bit so the last bit shifted out lands in it;
    // oversized counts fall out naturally as zero / sign fill.
    logic        [W:0]  lsl_t, lsr_t;
    logic signed [W:0]  asr_t;
    logic        [PW:0] lslp_t, lsrp_t;
    logic signed [PW:0] asrp_t;

    assign lsl_t  = {1'b0, a_in_lo} << b_in;
    assign lsr_t  = {a_in_lo, 1'b0} >> b_in;
    assign asr_t  = $signed({a_in_lo, 1'b0}) >>> b_in;
    assign lslp_t = {1'b0, pair_in} << b_in;
    assign lsrp_t = {pair_in, 1'b0} >> b_in;
    assign asrp_t = $signed({pair_in, 1'b0}) >>> b_in;

    // Rotates are taken from a doubled copy of the operand; through-carry
    // rotates treat {C, operand} as one wider word.
    logic [W-1:0]  rot_amt, rotp_amt, rc_amt, rcp_amt;
    logic [W-1:0]  rol_r, ror_r;
    logic [PW-1:0] rolp_r, rorp_r;
    logic [W:0]    rc_src, rolc_r, rorc_r;
    logic [PW:0]   rcp_src, rolcp_r, rorcp_r;

    assign rot_amt  = b_in % ROT_W;
    assign rotp_amt = b_in % ROT_PW;
    assign rc_amt   = b_in % ROT_W1;
    assign rcp_amt  = b_in % ROT_PW1;
    assign rol_r    = W'(({a_in_lo, a_in_lo} << rot_amt) >> W);
    assign ror_r    = W'({a_in_lo, a_in_lo} >> rot_amt);
    assign rolp_r   = PW'(({pair_in, pair_in} << rotp_amt) >> PW);
    assign rorp_r   = PW'({pair_in, pair_in} >> rotp_amt);
    assign rc_src   = {c_in, a_in_lo};
    assign rcp_src  = {c_in, pair_in};
    assign rolc_r   = W1'(({rc_src, rc_src} << rc_amt) >> W1);
    assign rorc_r   = W1'({rc_src, rc_src} >> rc_amt);
    assign rolcp_r  = PW1'(({rcp_src, rcp_src} << rcp_amt) >> PW1);
    assign rorcp_r  = PW1'({rcp_src, rcp_src} >> rcp_amt);

    logic [PW-1:0]          res, zn_val;
    logic                   c_new, v_new, pair_op, op_valid, z_new, n_new;
    logic [FLAGS_WIDTH-1:0] flags_next;

    // Select the result and C/V for the current opcode, then derive Z/N.
    always_comb begin
        res      = '0;
        c_new    = c_in;
        v_new    = v_in;
        pair_op  = 1'b0;
        op_valid = 1'b1;
        case (oper)
            OP_ADD, OP_ADC: begin
                res   = {{W{1'b0}}, add_full[W-1:0]};
                c_new = add_full[W];
                v_new = add_v;
            end
            OP_SUB, OP_SBC, OP_NEG: begin
                res   = {{W{1'b0}}, sub_full[W-1:0]};
                c_new = sub_c;
                v_new = sub_v;
            end
            OP_CMP: begin
                res   = {{W{1'b0}}, a_in_lo};
                c_new = sub_c;
                v_new = sub_v;
            end
            OP_AND:  res = {{W{1'b0}}, a_in_lo & b_in};
            OP_ORR:  res = {{W{1'b0}}, a_in_lo | b_in};
            OP_XOR:  res = {{W{1'b0}}, a_in_lo ^ b_in};
            OP_INV:  res = {{W{1'b0}}, ~a_in_lo};
            OP_INVP: begin
                res     = ~pair_in;
                pair_op = 1'b1;
            end
            OP_NEGP: begin
                res     = negp_full[PW-1:0];
                c_new   = ~negp_full[PW];
                v_new   = pair_in[PW-1] & negp_full[PW-1];
                pair_op = 1'b1;
            end
            OP_LSL: begin
                res = {{W{1'b0}}, lsl_t[W-1:0]};
                if (b_in != '0) c_new = lsl_t[W];
            end
            OP_LSR: begin
                res = {{W{1'b0}}, lsr_t[W:1]};
                if (b_in != '0) c_new = lsr_t[0];
            end
            OP_ASR: begin
                res = {{W{1'b0}}, asr_t[W:1]};
                if (b_in != '0) c_new = asr_t[0];
            end
            OP_ROL:  res = {{W{1'b0}}, rol_r};
            OP_ROR:  res = {{W{1'b0}}, ror_r};
            OP_ROLC: begin
                res   = {{W{1'b0}}, rolc_r[W-1:0]};
                c_new = rolc_r[W];
            end
            OP_RORC: begin
                res   = {{W{1'b0}}, rorc_r[W-1:0]};
                c_new = rorc_r[W];
            end
            OP_LSLP: begin
                res     = lslp_t[PW-1:0];
                pair_op = 1'b1;
                if (b_in != '0) c_new = lslp_t[PW];
            end
            OP_LSRP: begin
                res     = lsrp_t[PW:1];
                pair_op = 1'b1;
                if (b_in != '0) c_new = lsrp_t[0];
            end
            OP_ASRP: begin
                res     = asrp_t[PW:1];
                pair_op = 1'b1;
                if (b_in != '0) c_new = asrp_t[0];
            end
            OP_ROLP: begin
                res     = rolp_r;
                pair_op = 1'b1;
            end
            OP_RORP: begin
                res     = rorp_r;
                pair_op = 1'b1;
            end
            OP_ROLCP: begin
                res     = rolcp_r[PW-1:0];
                c_new   = rolcp_r[PW];
                pair_op = 1'b1;
            end
            OP_RORCP: begin
                res     = rorcp_r[PW-1:0];
                c_new   = rorcp_r[PW];
                pair_op = 1'b1;
            end
            default: op_valid = 1'b0;
        endcase

        // cmp reports Z/N of the discarded difference, not of the passed-through a.
        zn_val     = (oper == OP_CMP) ? {{W{1'b0}}, sub_full[W-1:0]} : res;
        z_new      = pair_op ? (zn_val == '0) : (zn_val[W-1:0] == '0);
        n_new      = pair_op ? zn_val[PW-1] : zn_val[W-1];
        flags_next = op_valid ? {n_new, v_new, c_new, z_new} : proc_flags_in;
    end

    // Register result and flags; async clear on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_lo         <= '0;
            out_hi         <= '0;
            proc_flags_out <= '0;
        end else begin
            out_lo         <= res[W-1:0];
            out_hi         <= res[PW-1:W];
            proc_flags_out <= flags_next;
        end
    end

endmodule

// File: tb/tb_alu.sv
// Directed and randomized checks of alu against a bit-serial reference model.
module tb_alu;

    logic       clk;
    logic       rst_n;
    logic [4:0] oper;
    logic [7:0] a_in_lo, a_in_hi, b_in;
    logic [3:0] proc_flags_in;
    logic [7:0] out_lo, out_hi;
    logic [3:0] proc_flags_out;

    int n_tests = 0;
    int n_fail  = 0;

    logic [19:0] exp_q[$];

    alu dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .oper           (oper),
        .a_in_lo        (a_in_lo),
        .a_in_hi        (a_in_hi),
        .b_in           (b_in),
        .proc_flags_in  (proc_flags_in),
        .out_lo         (out_lo),
        .out_hi         (out_hi),
        .proc_flags_out (proc_flags_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int sgn8(input logic [7:0] x);
        return x[7] ? int'(x) - 256 : int'(x);
    endfunction

    function automatic int sgn16(input logic [15:0] x);
        return x[15] ? int'(x) - 65536 : int'(x);
    endfunction

    // Reference model: {out_hi, out_lo, flags}; shifts/rotates one bit at a time.
    function automatic logic [19:0] model(input logic [4:0] op, input logic [7:0] al,
                                          input logic [7:0] ah, input logic [7:0] b,
                                          input logic [3:0] fi);
        int          s, ss, bin, n, wdt;
        logic        c, vf, pair, cc;
        logic [4:0]  base;
        logic [15:0] r, zn, p;
        logic [16:0] v, m;
        logic        zf, nf;
        if (op > 5'd25) return {16'h0000, fi};
        c    = fi[1];
        vf   = fi[2];
        p    = {ah, al};
        pair = (op >= 5'd19) || (op == 5'd9) || (op == 5'd11);
        base = (op >= 5'd19) ? op - 5'd7 : op;
        wdt  = pair ? 16 : 8;
        m    = (17'd1 << wdt) - 17'd1;
        v    = pair ? {1'b0, p} : {9'd0, al};
        r    = 16'h0000;
        zn   = 16'h0000;
        case (base)
            5'd0, 5'd1: begin
                bin = (base == 5'd1) ? int'(c) : 0;
                s   = int'(al) + int'(b) + bin;
                ss  = sgn8(al) + sgn8(b) + bin;
                r   = 16'(s & 255);
                c   = s > 255;
                vf  = (ss > 127) || (ss < -128);
            end
            5'd2, 5'd3, 5'd4, 5'd10: begin
                bin = (base == 5'd3 && !c) ? 1 : 0;
                if (base == 5'd10) begin
                    s  = 0 - int'(al);
                    ss = 0 - sgn8(al);
                end else begin
                    s  = int'(al) - int'(b) - bin;
                    ss = sgn8(al) - sgn8(b) - bin;
                end
                r  = 16'(s & 255);
                c  = s >= 0;
                vf = (ss > 127) || (ss < -128);
            end
            5'd5: r = {8'h00, al & b};
            5'd6: r = {8'h00, al | b};
            5'd7: r = {8'h00, al ^ b};
            5'd8: r = {8'h00, ~al};
            5'd9: r = ~p;
            5'd11: begin
                s  = 0 - int'(p);
                ss = 0 - sgn16(p);
                r  = 16'(s & 65535);
                c  = (p == 16'h0000);
                vf = (ss > 32767) || (ss < -32768);
            end
            5'd12, 5'd13, 5'd14: begin
                for (int k = 0; k < int'(b); k++) begin
                    if (base == 5'd12) begin
                        c = v[wdt-1];
                        v = (v << 1) & m;
                    end else begin
                        cc = v[wdt-1];
                        c  = v[0];
                        v  = v >> 1;
                        if (base == 5'd14) v = v | (17'(cc) << (wdt - 1));
                    end
                end
                r = v[15:0];
            end
            5'd15, 5'd16: begin
                n = int'(b) % wdt;
                for (int k = 0; k < n; k++) begin
                    if (base == 5'd15) begin
                        cc = v[wdt-1];
                        v  = ((v << 1) & m) | 17'(cc);
                    end else begin
                        cc = v[0];
                        v  = (v >> 1) | (17'(cc) << (wdt - 1));
                    end
                end
                r = v[15:0];
            end
            default: begin
                n = int'(b) % (wdt + 1);
                for (int k = 0; k < n; k++) begin
                    if (base == 5'd17) begin
                        cc = v[wdt-1];
                        v  = ((v << 1) & m) | 17'(c);
                    end else begin
                        cc = v[0];
                        v  = (v >> 1) | (17'(c) << (wdt - 1));
                    end
                    c = cc;
                end
                r = v[15:0];
            end
        endcase
        zn = r;
        if (base == 5'd4) r = {8'h00, al};
        zf = pair ? (zn == 16'h0000) : (zn[7:0] == 8'h00);
        nf = pair ? zn[15] : zn[7];
        return {r, nf, vf, c, zf};
    endfunction

    task automatic check(input string tag, input logic [19:0] obs, input logic [19:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic drive(input logic [4:0] op, input logic [7:0] al, input logic [7:0] ah,
                         input logic [7:0] b, input logic [3:0] fi);
        @(negedge clk);
        oper          = op;
        a_in_lo       = al;
        a_in_hi       = ah;
        b_in          = b;
        proc_flags_in = fi;
    endtask

    task automatic collect(input string tag);
        logic [19:0] e;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL %s observed=no_expectation expected=queued_result", tag);
        end else begin
            e = exp_q.pop_front();
            check(tag, {out_hi, out_lo, proc_flags_out}, e);
        end
    endtask

    // Step checked against the reference model.
    task automatic step(input string tag, input logic [4:0] op, input logic [7:0] al,
                        input logic [7:0] ah, input logic [7:0] b, input logic [3:0] fi);
        drive(op, al, ah, b, fi);
        exp_q.push_back(model(op, al, ah, b, fi));
        collect(tag);
    endtask

    // Step checked against a hand-derived constant.
    task automatic dstep(input string tag, input logic [4:0] op, input logic [7:0] al,
                         input logic [7:0] ah, input logic [7:0] b, input logic [3:0] fi,
                         input logic [19:0] e);
        drive(op, al, ah, b, fi);
        exp_q.push_back(e);
        collect(tag);
    endtask

    initial begin
        logic [7:0] ra, rh, rb;
        logic [3:0] rf;
        rst_n         = 1'b0;
        oper          = 5'd0;
        a_in_lo       = 8'h00;
        a_in_hi       = 8'h00;
        b_in          = 8'h00;
        proc_flags_in = 4'h0;
        #3;
        check("reset_initial", {out_hi, out_lo, proc_flags_out}, 20'h00000);
        @(negedge clk);
        rst_n = 1'b1;

        dstep("add_7f_01", 5'd0, 8'h7F, 8'h00, 8'h01, 4'b0000, {8'h00, 8'h80, 4'b1100});
        dstep("adc_ff_00_c1", 5'd1, 8'hFF, 8'h00, 8'h00, 4'b0010, {8'h00, 8'h00, 4'b0011});
        dstep("sub_00_01", 5'd2, 8'h00, 8'h00, 8'h01, 4'b0000, {8'h00, 8'hFF, 4'b1000});
        dstep("cmp_05_05", 5'd4, 8'h05, 8'h00, 8'h05, 4'b0000, {8'h00, 8'h05, 4'b0011});
        dstep("neg_80", 5'd10, 8'h80, 8'h00, 8'h00, 4'b0000, {8'h00, 8'h80, 4'b1100});
        dstep("negp_0001", 5'd11, 8'h01, 8'h00, 8'h00, 4'b0000, {8'hFF, 8'hFF, 4'b1000});
        dstep("lsl_81_1", 5'd12, 8'h81, 8'h00, 8'h01, 4'b0000, {8'h00, 8'h02, 4'b0010});
        dstep("lsl_81_8", 5'd12, 8'h81, 8'h00, 8'h08, 4'b0000, {8'h00, 8'h00, 4'b0011});
        dstep("lsl_81_9", 5'd12, 8'h81, 8'h00, 8'h09, 4'b0010, {8'h00, 8'h00, 4'b0001});
        dstep("asr_80_9", 5'd14, 8'h80, 8'h00, 8'h09, 4'b0000, {8'h00, 8'hFF, 4'b1010});
        dstep("lsr_5a_0", 5'd13, 8'h5A, 8'h00, 8'h00, 4'b0110, {8'h00, 8'h5A, 4'b0110});
        dstep("rolc_80_c0_1", 5'd17, 8'h80, 8'h00, 8'h01, 4'b0000, {8'h00, 8'h00, 4'b0011});
        dstep("rorcp_0001_c1_17", 5'd25, 8'h01, 8'h00, 8'd17, 4'b0010, {8'h00, 8'h01, 4'b0010});
        dstep("rolp_8001_4", 5'd22, 8'h01, 8'h80, 8'h04, 4'b0000, {8'h00, 8'h18, 4'b0000});
        dstep("op27_passthru", 5'd27, 8'h12, 8'h34, 8'h56, 4'b1011, {8'h00, 8'h00, 4'b1011});
        dstep("lsrp_8000_16", 5'd20, 8'h00, 8'h80, 8'd16, 4'b0000, {8'h00, 8'h00, 4'b0011});
        dstep("invp_00f0", 5'd9, 8'hF0, 8'h00, 8'h00, 4'b0110, {8'hFF, 8'h0F, 4'b1110});

        // Async reset with add FF+01 pending, then release.
        drive(5'd0, 8'hFF, 8'h00, 8'h01, 4'b0000);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async", {out_hi, out_lo, proc_flags_out}, 20'h00000);
        @(posedge clk);
        #1;
        check("rst_hold", {out_hi, out_lo, proc_flags_out}, 20'h00000);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back({8'h00, 8'h00, 4'b0011});
        collect("rst_release_add");

        // Shift and rotate counts swept across the width boundaries.
        for (int op = 12; op <= 25; op++) begin
            for (int cnt = 0; cnt <= 20; cnt++) begin
                step($sformatf("count op%0d n%0d", op, cnt), 5'(op), 8'h96, 8'hC3,
                     8'(cnt), 4'(cnt & 6));
            end
        end

        // Randomized sweep over every opcode.
        for (int op = 0; op < 32; op++) begin
            for (int i = 0; i < 1200; i++) begin
                ra = 8'($urandom);
                rh = 8'($urandom);
                rb = ((op >= 12) && (op <= 25) && (i[0] == 1'b1))
                     ? 8'($urandom_range(0, 40)) : 8'($urandom);
                rf = 4'($urandom);
                step($sformatf("sweep op%0d", op), 5'(op), ra, rh, rb, rf);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
